// File: rtl/signed_divider_pkg.sv
// Shared constants and state encoding for the iterative restoring divider.
package signed_divider_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int ITER_COUNT    = 32;
  localparam int CNT_W         = 5;

  // Quotient returned when the divisor is zero.
  localparam logic [DEFAULT_WIDTH-1:0] DIV0_QUOTIENT = {DEFAULT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/signed_divider_step.sv
// One combinational radix-2 restoring step.
// The partial remainder is WIDTH+1 bits wide so the trial subtract keeps its carry.
module divider_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   p_in,
  input  logic [WIDTH-1:0] n_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   p_out,
  output logic [WIDTH-1:0] n_out
);

  logic [WIDTH:0] p_shift_s;
  logic [WIDTH:0] diff_s;

  // Shift the next dividend bit into P, then keep the difference if it did not go negative.
  always_comb begin
    p_shift_s = {p_in[WIDTH-1:0], n_in[WIDTH-1]};
    diff_s    = p_shift_s - {1'b0, d};
    if (p_shift_s >= {1'b0, d}) begin
      p_out = diff_s;
      n_out = {n_in[WIDTH-2:0], 1'b1};
    end else begin
      p_out = p_shift_s;
      n_out = {n_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/signed_divider.sv
// Iterative 32/32 signed/unsigned divider: IDLE -> ITER (32 cycles) -> FIX -> IDLE.
// Operands are reduced to magnitudes on entry and the signs are re-applied in FIX,
// so latency is the same for every operand value.
module signed_divider
  import signed_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done
);

  state_t           state_r;
  logic [CNT_W-1:0] counter_r;
  logic [WIDTH:0]   p_r;
  logic [WIDTH-1:0] n_r;
  logic [WIDTH-1:0] d_r;
  logic             sign_q_r;
  logic             sign_r_r;
  logic             zero_r;
  logic             ovf_r;

  logic             neg_a_s;
  logic             neg_b_s;
  logic [WIDTH-1:0] abs_a_s;
  logic [WIDTH-1:0] abs_b_s;
  logic             ovf_s;
  logic [WIDTH:0]   p_next_s;
  logic [WIDTH-1:0] n_next_s;
  logic [WIDTH-1:0] q_fix_s;
  logic [WIDTH-1:0] r_fix_s;

  localparam logic [WIDTH-1:0] ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MIN_NEG_W = {1'b1, {(WIDTH-1){1'b0}}};

  // Operand magnitudes; the most negative value maps onto itself, which reads correctly as unsigned.
  always_comb begin
    neg_a_s = is_signed & dividend[WIDTH-1];
    neg_b_s = is_signed & divisor[WIDTH-1];
    if (neg_a_s) begin
      abs_a_s = ~dividend + ONE_W;
    end else begin
      abs_a_s = dividend;
    end
    if (neg_b_s) begin
      abs_b_s = ~divisor + ONE_W;
    end else begin
      abs_b_s = divisor;
    end
    ovf_s = is_signed & (dividend == MIN_NEG_W) & (divisor == {WIDTH{1'b1}});
  end

  divider_step #(.WIDTH(WIDTH)) u_step (
    .p_in  (p_r),
    .n_in  (n_r),
    .d     (d_r),
    .p_out (p_next_s),
    .n_out (n_next_s)
  );

  // Re-apply signs and resolve divide-by-zero and signed overflow for the final load.
  always_comb begin
    if (zero_r) begin
      q_fix_s = DIV0_QUOTIENT[WIDTH-1:0];
    end else if (ovf_r) begin
      q_fix_s = MIN_NEG_W;
    end else if (sign_q_r) begin
      q_fix_s = ~n_r + ONE_W;
    end else begin
      q_fix_s = n_r;
    end
    // With a zero divisor P ends as |dividend|, so re-signing it returns the raw dividend.
    if (ovf_r) begin
      r_fix_s = {WIDTH{1'b0}};
    end else if (sign_r_r) begin
      r_fix_s = ~p_r[WIDTH-1:0] + ONE_W;
    end else begin
      r_fix_s = p_r[WIDTH-1:0];
    end
  end

  // Control FSM, iteration datapath and registered results.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      counter_r <= {CNT_W{1'b0}};
      p_r       <= {(WIDTH+1){1'b0}};
      n_r       <= {WIDTH{1'b0}};
      d_r       <= {WIDTH{1'b0}};
      sign_q_r  <= 1'b0;
      sign_r_r  <= 1'b0;
      zero_r    <= 1'b0;
      ovf_r     <= 1'b0;
      quotient  <= {WIDTH{1'b0}};
      remainder <= {WIDTH{1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            n_r       <= abs_a_s;
            d_r       <= abs_b_s;
            p_r       <= {(WIDTH+1){1'b0}};
            sign_q_r  <= neg_a_s ^ neg_b_s;
            sign_r_r  <= neg_a_s;
            zero_r    <= (divisor == {WIDTH{1'b0}});
            ovf_r     <= ovf_s;
            counter_r <= {CNT_W{1'b0}};
            busy      <= 1'b1;
            state_r   <= ITER;
          end else begin
            state_r <= IDLE;
          end
        end
        ITER: begin
          p_r       <= p_next_s;
          n_r       <= n_next_s;
          counter_r <= counter_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (counter_r == CNT_W'(ITER_COUNT - 1)) begin
            state_r <= FIX;
          end else begin
            state_r <= ITER;
          end
        end
        FIX: begin
          quotient  <= q_fix_s;
          remainder <= r_fix_s;
          done      <= 1'b1;
          busy      <= 1'b0;
          state_r   <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signed_divider.sv
// Self-checking bench for signed_divider: directed corner cases plus randomized
// operands compared against a plain-arithmetic reference model.
module tb_signed_divider;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;

  int checks;
  int failures;

  signed_divider dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: truncating division, remainder takes the dividend's sign.
  task automatic ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, tq, tr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      tq = sa / sb;
      tr = sa % sb;
      q  = tq[31:0];
      r  = tr[31:0];
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // Present an operation in the low phase; it is sampled at the next rising edge.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    is_signed = s;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Wait for done counting rising edges from the one that sampled start (that edge is 1).
  // Optionally pulses a competing start at edge count inject_at.
  task automatic wait_done(input string tag, input logic [31:0] eq, input logic [31:0] er,
                           input int inject_at);
    int cnt;
    cnt = 1;
    while (done !== 1'b1 && cnt < 40) begin
      if (cnt == inject_at) begin
        is_signed = 1'b1;
        dividend  = 32'd7;
        divisor   = 32'd3;
        start     = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cnt++;
      if (cnt < 34 && done !== 1'b1) begin
        if (cnt == 2 || cnt == 33) chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      end
    end
    start = 1'b0;
    chk({tag, "_latency"}, cnt, 32'd34);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eq, er;
    ref_div(s, a, b, eq, er);
    issue(s, a, b);
    wait_done(tag, eq, er, -1);
  endtask

  initial begin
    logic [31:0] eq, er, a, b, hold_q;
    int saw_done;
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = 32'd0;
    divisor   = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;

    // Directed cases with hand-derived results.
    issue(1'b0, 32'd100, 32'd7);
    wait_done("u100_7", 32'h0000_000E, 32'd2, -1);
    hold_q = quotient;
    @(posedge clk);
    #1;
    chk("done_pulse", {31'd0, done}, 32'd0);
    chk("hold_q", quotient, hold_q);
    issue(1'b1, 32'hFFFF_FF9C, 32'd7);
    wait_done("s-100_7", 32'hFFFF_FFF2, 32'hFFFF_FFFE, -1);
    issue(1'b1, 32'd100, 32'hFFFF_FFF9);
    wait_done("s100_-7", 32'hFFFF_FFF2, 32'd2, -1);
    issue(1'b0, 32'd5, 32'd0);
    wait_done("u5_0", 32'hFFFF_FFFF, 32'd5, -1);
    issue(1'b1, 32'd5, 32'd0);
    wait_done("s5_0", 32'hFFFF_FFFF, 32'd5, -1);
    issue(1'b1, 32'hFFFF_FFFB, 32'd0);
    wait_done("s-5_0", 32'hFFFF_FFFF, 32'hFFFF_FFFB, -1);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("s_ovf", 32'h8000_0000, 32'd0, -1);
    issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("u_ovfops", 32'd0, 32'h8000_0000, -1);

    // Competing start mid-operation is ignored; a start in the done cycle is accepted.
    issue(1'b0, 32'hFFFF_FFFF, 32'd2);
    wait_done("u_ign", 32'h7FFF_FFFF, 32'd1, 10);
    issue(1'b1, 32'h8000_0000, 32'd3);
    wait_done("b2b", 32'hD555_5556, 32'hFFFF_FFFE, -1);

    // Reset in the middle of an operation aborts it without a done pulse.
    issue(1'b0, 32'd1000, 32'd9);
    repeat (11) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_q", quotient, 32'd0);
    chk("midrst_r", remainder, 32'd0);
    saw_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) saw_done = 1;
    end
    chk("midrst_nodone", saw_done, 32'd0);
    issue(1'b0, 32'd9, 32'd3);
    wait_done("u9_3", 32'd3, 32'd0, -1);

    // Randomized operands against the reference model.
    for (int k = 0; k < 24; k++) begin
      logic s;
      int sel;
      s   = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 3);
      a   = $urandom;
      case (sel)
        0: b = $urandom;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'd0;
        default: b = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(1, 300)) << 20;
      endcase
      if (k == 5) a = 32'h8000_0000;
      ref_div(s, a, b, eq, er);
      issue(s, a, b);
      wait_done($sformatf("rnd%0d", k), eq, er, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
